// File: rtl/game_sprite_motion.sv
// Sprite position/velocity engine with registered per-pixel hit output.
// Optional motion prescaler enabled by defining GAME_SPRITE_PRESCALER_EN.
module game_sprite_motion #(
  parameter int         X_WIDTH       = 10,
  parameter int         Y_WIDTH       = 10,
  parameter int         DXY_WIDTH     = 3,
  parameter int         SCREEN_WIDTH  = 640,
  parameter int         SCREEN_HEIGHT = 480,
  parameter int         SPRITE_WIDTH  = 8,
  parameter int         SPRITE_HEIGHT = 8,
  parameter logic [2:0] SPRITE_COLOR  = 3'b110,
  parameter int         UPDATE_PERIOD = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [X_WIDTH-1:0]   pixel_x,
  input  logic [Y_WIDTH-1:0]   pixel_y,
  input  logic                 write_xy,
  input  logic                 write_dxy,
  input  logic [X_WIDTH-1:0]   x_in,
  input  logic [Y_WIDTH-1:0]   y_in,
  input  logic [DXY_WIDTH-1:0] dx_in,
  input  logic [DXY_WIDTH-1:0] dy_in,
  input  logic                 enable_update,
  output logic [X_WIDTH-1:0]   sprite_x,
  output logic [Y_WIDTH-1:0]   sprite_y,
  output logic                 within_screen,
  output logic                 rgb_en,
  output logic [2:0]           rgb
);

  localparam logic [X_WIDTH-1:0] X_MAX = X_WIDTH'(SCREEN_WIDTH - SPRITE_WIDTH);
  localparam logic [Y_WIDTH-1:0] Y_MAX = Y_WIDTH'(SCREEN_HEIGHT - SPRITE_HEIGHT);

  if (UPDATE_PERIOD < 1) begin : g_period_check
    $error("UPDATE_PERIOD must be at least 1");
  end

  logic [X_WIDTH-1:0]   x;
  logic [Y_WIDTH-1:0]   y;
  logic [DXY_WIDTH-1:0] dx;
  logic [DXY_WIDTH-1:0] dy;
  logic                 step_tick;
  logic                 step;
  logic [X_WIDTH-1:0]   x_next;
  logic [Y_WIDTH-1:0]   y_next;
  logic [X_WIDTH:0]     x_end;
  logic [Y_WIDTH:0]     y_end;
  logic                 hit;

`ifdef GAME_SPRITE_PRESCALER_EN
  localparam int CNT_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPDATE_PERIOD - 1);

  logic [CNT_W-1:0] count;

  assign step_tick = (count == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable_update || write_xy || step_tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end
`else
  assign step_tick = 1'b1;
`endif

  assign step   = enable_update && step_tick;
  assign x_next = x + {{(X_WIDTH-DXY_WIDTH){dx[DXY_WIDTH-1]}}, dx};
  assign y_next = y + {{(Y_WIDTH-DXY_WIDTH){dy[DXY_WIDTH-1]}}, dy};

  // Velocity loads and the step both read the pre-edge dx/dy, so a
  // simultaneous write_dxy only affects the following step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x  <= '0;
      y  <= '0;
      dx <= '0;
      dy <= '0;
    end else begin
      if (write_xy) begin
        x <= x_in;
        y <= y_in;
      end else if (step) begin
        x <= x_next;
        y <= y_next;
      end
      if (write_dxy) begin
        dx <= dx_in;
        dy <= dy_in;
      end
    end
  end

  // One extra bit on the box end so a sprite near the top of the range
  // cannot wrap and match low pixel coordinates.
  assign x_end = {1'b0, x} + (X_WIDTH+1)'(SPRITE_WIDTH);
  assign y_end = {1'b0, y} + (Y_WIDTH+1)'(SPRITE_HEIGHT);
  assign hit   = (pixel_x >= x) && ({1'b0, pixel_x} < x_end) &&
                 (pixel_y >= y) && ({1'b0, pixel_y} < y_end);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_en <= 1'b0;
    end else begin
      rgb_en <= hit;
    end
  end

  assign rgb           = rgb_en ? SPRITE_COLOR : 3'b000;
  assign within_screen = (x <= X_MAX) && (y <= Y_MAX);
  assign sprite_x      = x;
  assign sprite_y      = y;

endmodule
